// File: rtl/cordic_atan_scheduler_if.sv
// Requester, response and engine signal bundle for the CORDIC atan scheduler.
// The scheduler uses the slave modport; requesters, consumer and engine sit on master.
interface cordic_atan_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_x;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_y;
  logic                               resp_valid;
  logic                               resp_ready;
  logic [ID_W-1:0]                    resp_id;
  logic [DATA_WIDTH-1:0]              resp_angle;
  logic                               resp_err;
  logic                               eng_start;
  logic [DATA_WIDTH-1:0]              eng_x;
  logic [DATA_WIDTH-1:0]              eng_y;
  logic                               eng_done;
  logic [DATA_WIDTH-1:0]              eng_angle;

  modport master (
    output req_valid, req_x, req_y, resp_ready, eng_done, eng_angle,
    input  req_ready, resp_valid, resp_id, resp_angle, resp_err, eng_start, eng_x, eng_y
  );

  modport slave (
    input  req_valid, req_x, req_y, resp_ready, eng_done, eng_angle,
    output req_ready, resp_valid, resp_id, resp_angle, resp_err, eng_start, eng_x, eng_y
  );
endinterface

// File: rtl/cordic_atan_scheduler.sv
// Round-robin arbiter that serialises NUM_REQ requesters onto one CORDIC atan
// engine, one transaction in flight, with a completion timeout.
module cordic_atan_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 64
) (
  input logic                    clk,
  input logic                    resetn,
  cordic_atan_scheduler_if.slave bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       grant_id;
  logic [ID_W-1:0]       sel_id;
  logic                  sel_hit;
  logic [DATA_WIDTH-1:0] op_x;
  logic [DATA_WIDTH-1:0] op_y;
  logic [DATA_WIDTH-1:0] angle_q;
  logic                  err_q;
  logic                  start_q;
  logic                  valid_q;
  logic [CNT_W-1:0]      wait_cnt;

  // Scan offsets high to low so the lowest offset from rr_ptr is the one kept.
  always_comb begin
    int idx;
    idx     = 0;
    sel_hit = 1'b0;
    sel_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (bus.req_valid[idx]) begin
        sel_hit = 1'b1;
        sel_id  = ID_W'(idx);
      end
    end
  end

  // Grant is combinational so a requester sees its accept in the same cycle.
  always_comb begin
    bus.req_ready = '0;
    if (resetn && state == IDLE && sel_hit) bus.req_ready[sel_id] = 1'b1;
  end

  assign bus.eng_x      = op_x;
  assign bus.eng_y      = op_y;
  assign bus.eng_start  = start_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_id    = grant_id;
  assign bus.resp_angle = angle_q;
  assign bus.resp_err   = err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      op_x     <= '0;
      op_y     <= '0;
      angle_q  <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_hit) begin
            op_x     <= bus.req_x[sel_id];
            op_y     <= bus.req_y[sel_id];
            grant_id <= sel_id;
            start_q  <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          start_q  <= 1'b0;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (bus.eng_done) begin
            angle_q <= bus.eng_angle;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            state   <= RESP;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 2)) begin
            // Counter would reach TIMEOUT-1 this cycle: give up on the engine.
            angle_q <= '0;
            err_q   <= 1'b1;
            valid_q <= 1'b1;
            state   <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            valid_q <= 1'b0;
            rr_ptr  <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_atan_scheduler.sv
// Randomised self-checking bench for cordic_atan_scheduler with a behavioural
// engine model and a round-robin / latency reference model.
module tb_cordic_atan_scheduler;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cordic_atan_scheduler_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  cordic_atan_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Engine model: eng_done fires eng_delay cycles after the eng_start cycle
  // (never when eng_delay is 0); it is deliberately not reset with the DUT.
  int          eng_delay = 0;
  int          eng_cnt   = 0;
  int          kick_req  = 0;
  int          kick_ack  = 0;
  logic [DW-1:0] eng_result = '0;

  always @(negedge clk) begin
    bus.eng_done = 1'b0;
    if (kick_req != kick_ack) begin
      kick_ack       = kick_req;
      bus.eng_done   = 1'b1;
      bus.eng_angle  = eng_result;
    end else if (bus.eng_start && eng_delay > 0) begin
      eng_cnt = eng_delay;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        bus.eng_done  = 1'b1;
        bus.eng_angle = eng_result;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.req_valid = '0;
    bus.resp_ready = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.req_valid = '1;
    bus.req_x = '1;
    bus.req_y = '1;
    repeat (2) tick();
    n_tests++;
    if (bus.req_ready !== '0) begin
      n_fail++; $display("FAIL reset_req_ready got %b exp 0000", bus.req_ready);
    end
    n_tests++;
    if ({bus.resp_valid, bus.resp_err, bus.eng_start} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b exp 000", {bus.resp_valid, bus.resp_err, bus.eng_start});
    end
    n_tests++;
    if (bus.resp_id !== '0 || bus.resp_angle !== '0) begin
      n_fail++; $display("FAIL reset_resp got id=%0d angle=%h exp 0/0", bus.resp_id, bus.resp_angle);
    end
    n_tests++;
    if (bus.eng_x !== '0 || bus.eng_y !== '0) begin
      n_fail++; $display("FAIL reset_operands got %h/%h exp 0/0", bus.eng_x, bus.eng_y);
    end
    bus.req_valid = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int cyc;
    eng_delay = 16;
    eng_result = 32'h0000ABCD;
    bus.req_x[2] = 32'h00010000;
    bus.req_y[2] = '0;
    bus.req_valid = 4'b0100;
    #1;
    n_tests++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL single_accept got %b exp 0100", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    n_tests++;
    if (bus.eng_start !== 1'b1 || bus.eng_x !== 32'h00010000 || bus.eng_y !== '0) begin
      n_fail++; $display("FAIL single_start got start=%b x=%h y=%h exp 1/00010000/0", bus.eng_start, bus.eng_x, bus.eng_y);
    end
    cyc = 0;
    while (bus.resp_valid !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    n_tests++;
    if (cyc != 17) begin
      n_fail++; $display("FAIL single_latency got %0d exp 17", cyc);
    end
    n_tests++;
    if (bus.resp_id !== 2'd2 || bus.resp_angle !== 32'h0000ABCD || bus.resp_err !== 1'b0) begin
      n_fail++; $display("FAIL single_resp got id=%0d angle=%h err=%b exp 2/0000abcd/0", bus.resp_id, bus.resp_angle, bus.resp_err);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    n_tests++;
    if (bus.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_handshake got resp_valid=%b exp 0", bus.resp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] xs [NR];
    logic [NR-1:0] exp_rdy;
    logic [DW-1:0] res;
    int cyc;
    bit busy_bad;
    do_reset();
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NR; i++) begin xs[i] = $urandom; bus.req_x[i] = xs[i]; end
      res = $urandom;
      eng_delay = $urandom_range(1, 6);
      eng_result = res;
      bus.req_valid = '1;
      #1;
      exp_rdy = '0;
      exp_rdy[k % NR] = 1'b1;
      n_tests++;
      if (bus.req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rr_grant[%0d] got %b exp %b", k, bus.req_ready, exp_rdy);
      end
      tick();
      cyc = 0;
      busy_bad = 1'b0;
      while (bus.resp_valid !== 1'b1 && cyc < 100) begin
        tick(); cyc++;
        if (bus.req_ready !== '0) busy_bad = 1'b1;
      end
      n_tests++;
      if (busy_bad || bus.resp_id !== 2'(k % NR) || bus.resp_angle !== res || bus.eng_x !== xs[k % NR]) begin
        n_fail++; $display("FAIL rr_resp[%0d] got id=%0d angle=%h busy=%b exp %0d/%h/0", k, bus.resp_id, bus.resp_angle, busy_bad, k % NR, res);
      end
      tick();
    end
    bus.resp_ready = 1'b0;
    bus.req_valid = '0;
  endtask

  task automatic test_timeout();
    int dl [3] = '{0, 63, 64};
    int cyc;
    int exp_lat;
    bit exp_err;
    logic [DW-1:0] res;
    for (int k = 0; k < 3; k++) begin
      res = $urandom;
      eng_delay = dl[k];
      eng_result = res;
      bus.req_x[3] = $urandom;
      bus.req_valid = 4'b1000;
      tick();
      bus.req_valid = '0;
      cyc = 0;
      while (bus.resp_valid !== 1'b1 && cyc < 200) begin tick(); cyc++; end
      exp_err = (dl[k] == 0 || dl[k] >= TO);
      exp_lat = exp_err ? TO : dl[k] + 1;
      n_tests++;
      if (cyc != exp_lat) begin
        n_fail++; $display("FAIL timeout_latency[d=%0d] got %0d exp %0d", dl[k], cyc, exp_lat);
      end
      n_tests++;
      if (bus.resp_err !== exp_err || bus.resp_angle !== (exp_err ? '0 : res)) begin
        n_fail++; $display("FAIL timeout_resp[d=%0d] got err=%b angle=%h exp %b/%h", dl[k], bus.resp_err, bus.resp_angle, exp_err, exp_err ? '0 : res);
      end
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] res;
    int cyc;
    res = $urandom;
    eng_delay = 4;
    eng_result = res;
    bus.req_x[0] = $urandom;
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'b0010;
    cyc = 0;
    while (bus.resp_valid !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0 || bus.resp_angle !== res ||
          bus.resp_err !== 1'b0 || bus.req_ready !== '0) begin
        n_fail++; $display("FAIL stall_hold[%0d] got v=%b id=%0d angle=%h err=%b rdy=%b exp 1/0/%h/0/0000",
                           i, bus.resp_valid, bus.resp_id, bus.resp_angle, bus.resp_err, bus.req_ready, res);
      end
      tick();
    end
    bus.resp_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.req_ready !== '0) begin
      n_fail++; $display("FAIL stall_handshake_ready got %b exp 0000", bus.req_ready);
    end
    tick();
    bus.resp_ready = 1'b0;
    n_tests++;
    if (bus.req_ready !== 4'b0010 || bus.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_next_accept got rdy=%b v=%b exp 0010/0", bus.req_ready, bus.resp_valid);
    end
    tick();
    bus.req_valid = '0;
    cyc = 0;
    while (bus.resp_valid !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    n_tests++;
    if (bus.resp_id !== 2'd1 || bus.resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_second_resp got id=%0d v=%b exp 1/1", bus.resp_id, bus.resp_valid);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit bad;
    eng_delay = 10;
    eng_result = $urandom;
    bus.req_x[3] = $urandom;
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid = '0;
    repeat (4) tick();
    bus.req_valid = '1;
    resetn = 1'b0;
    #1;
    n_tests++;
    if (bus.req_ready !== '0 || bus.resp_id !== '0 || bus.eng_x !== '0 || bus.eng_start !== 1'b0) begin
      n_fail++; $display("FAIL midreset_async got rdy=%b id=%0d x=%h start=%b exp 0000/0/0/0",
                         bus.req_ready, bus.resp_id, bus.eng_x, bus.eng_start);
    end
    tick();
    resetn = 1'b1;
    bus.req_valid = '0;
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.resp_valid !== 1'b0 || bus.eng_start !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL midreset_late_done got activity=1 exp 0");
    end
    bus.req_valid = '1;
    #1;
    n_tests++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL midreset_first_grant got %b exp 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    cyc = 0;
    while (bus.resp_valid !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    n_tests++;
    if (bus.resp_id !== 2'd0 || bus.resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL midreset_resp got id=%0d v=%b exp 0/1", bus.resp_id, bus.resp_valid);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_idle_done();
    bit bad;
    int cyc;
    bus.req_valid = '0;
    eng_result = $urandom;
    kick_req++;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.resp_valid !== 1'b0 || bus.eng_start !== 1'b0 || bus.req_ready !== '0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL idle_done_ignored got activity=1 exp 0");
    end
    eng_delay = 3;
    bus.req_valid = 4'b0100;
    #1;
    n_tests++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL idle_done_accept got %b exp 0100", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    cyc = 0;
    while (bus.resp_valid !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    n_tests++;
    if (cyc != 4 || bus.resp_id !== 2'd2) begin
      n_fail++; $display("FAIL idle_done_resp got lat=%0d id=%0d exp 4/2", cyc, bus.resp_id);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  // Reference model: pending set per requester, pointer to the requester after the
  // last one served, and latency = delay+1 unless the engine never answers.
  task automatic test_random();
    logic [NR-1:0] pend;
    logic [NR-1:0] exp_rdy;
    logic [DW-1:0] px [NR];
    logic [DW-1:0] py [NR];
    logic [DW-1:0] res;
    int ptr, g, dly, cyc, stall, exp_lat;
    bit exp_err, busy_bad;
    do_reset();
    ptr = 0;
    pend = '0;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1; px[i] = $urandom; py[i] = $urandom;
        end
      end
      if (pend == '0) begin
        g = $urandom_range(0, NR - 1);
        pend[g] = 1'b1; px[g] = $urandom; py[g] = $urandom;
      end
      for (int i = 0; i < NR; i++) begin
        bus.req_x[i] = pend[i] ? px[i] : '0;
        bus.req_y[i] = pend[i] ? py[i] : '0;
      end
      bus.req_valid = pend;
      #1;
      g = -1;
      for (int k = 0; k < NR; k++) if (g < 0 && pend[(ptr + k) % NR]) g = (ptr + k) % NR;
      exp_rdy = '0;
      exp_rdy[g] = 1'b1;
      n_tests++;
      if (bus.req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rand_grant[%0d] got %b exp %b pend=%b", t, bus.req_ready, exp_rdy, pend);
      end
      dly = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
      res = $urandom;
      eng_delay = dly;
      eng_result = res;
      tick();
      pend[g] = 1'b0;
      bus.req_valid = pend;
      n_tests++;
      if (bus.eng_start !== 1'b1 || bus.eng_x !== px[g] || bus.eng_y !== py[g]) begin
        n_fail++; $display("FAIL rand_issue[%0d] got start=%b x=%h y=%h exp 1/%h/%h", t, bus.eng_start, bus.eng_x, bus.eng_y, px[g], py[g]);
      end
      cyc = 0;
      busy_bad = 1'b0;
      while (bus.resp_valid !== 1'b1 && cyc < 100) begin
        tick(); cyc++;
        if (bus.req_ready !== '0) busy_bad = 1'b1;
      end
      exp_err = (dly == 0);
      exp_lat = exp_err ? TO : dly + 1;
      n_tests++;
      if (cyc != exp_lat || busy_bad) begin
        n_fail++; $display("FAIL rand_latency[%0d] got %0d busy=%b exp %0d/0", t, cyc, busy_bad, exp_lat);
      end
      n_tests++;
      if (bus.resp_id !== 2'(g) || bus.resp_err !== exp_err || bus.resp_angle !== (exp_err ? '0 : res)) begin
        n_fail++; $display("FAIL rand_resp[%0d] got id=%0d err=%b angle=%h exp %0d/%b/%h",
                           t, bus.resp_id, bus.resp_err, bus.resp_angle, g, exp_err, exp_err ? '0 : res);
      end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        tick();
        n_tests++;
        if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'(g) || bus.req_ready !== '0) begin
          n_fail++; $display("FAIL rand_stall[%0d] got v=%b id=%0d rdy=%b exp 1/%0d/0000", t, bus.resp_valid, bus.resp_id, bus.req_ready, g);
        end
      end
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      n_tests++;
      if (bus.resp_valid !== 1'b0) begin
        n_fail++; $display("FAIL rand_handshake[%0d] got v=%b exp 0", t, bus.resp_valid);
      end
      ptr = (g + 1) % NR;
    end
    bus.req_valid = '0;
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_stall();
    test_reset_mid();
    test_idle_done();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
